cpu_sequencer: RTL
==================

// Module: cpu_sequencer
// PURPOSE
//  Multi-cycle fetch/decode/execute sequencer for the 8-bit CPU datapath.
//  Fetches two-byte instructions from the instruction ROM, then drives reg8x8, ALU and RAM256x8 control.
//  Owns PC, instruction registers and Z/C flags; sits between the ROM and the datapath.
// PARAMETERS
//  PC_W     8   ROM address/PC width; jump target = opcode2[PC_W-1:0]
//  RST_PC   0   PC value loaded on reset
// PORTS
//  clk            in   1     single clock, all state on posedge
//  res            in   1     synchronous, active-low reset
//  rom_addr       out  PC_W  ROM address (= pc)
//  rom_data       in   8     ROM byte, combinational from rom_addr
//  alu_zero       in   1     ALU Zero_f for current alu_func/operands
//  alu_carry      in   1     ALU Carry_f
//  alu_func       out  3     ALU function select
//  reg_rd_addr1   out  3     register read port 1 address
//  reg_rd_addr2   out  3     register read port 2 address
//  reg_wr_addr    out  3     register write address
//  reg_we         out  1     register write strobe; reg8x8 commits on its falling edge
//  reg_wsel       out  2     write-data mux: 0 ALU, 1 immediate (opcode2), 2 RAM data
//  imm            out  8     opcode2 (immediate / RAM address)
//  ram_n_cs       out  1     RAM chip select, active-low
//  ram_n_oe       out  1     RAM output enable, active-low
//  ram_n_we       out  1     RAM write enable, active-low
//  flag_z, flag_c out  1     latched flags
//  halted         out  1     core stopped (only with SEQ_HALT_EN)
// BEHAVIOUR
//  Encoding: op1[7]=1 ALU: func=op1[6:4], src1=op1[2:0], src2=op2[6:4], dst=op2[2:0].
//   op1[7:6]=01 JUMP: op1[5:4] 00 JMP, 01 JZ, 10 JC, 11 JNZ; target=op2.
//   op1[7:4]=0001 LDI dst=op1[2:0]; 0010 LDM dst<=RAM[op2]; 0011 STM RAM[op2]<=reg op1[2:0];
//   0000 NOP. Unused bits ignored.
//  States: FETCH1 -> FETCH2 -> EXEC -> (MEM for LDM/STM) -> FETCH1.
//  FETCH1: ir1<=rom_data, pc<=pc+1. FETCH2: ir2<=rom_data, pc<=pc+1.
//  EXEC ALU: drive addrs/func, reg_wsel=0, reg_we=1; flag_z<=alu_zero, flag_c<=alu_carry.
//  EXEC LDI: reg_wsel=1, reg_we=1. JUMP: pc<=op2 if taken, else pc unchanged. NOP: nothing.
//  EXEC LDM: n_cs=0,n_oe=0; MEM: n_cs=0,n_oe=0, reg_wsel=2, reg_we=1.
//  EXEC STM: rd_addr2=op1[2:0], n_cs=0,n_we=0,n_oe=1; MEM: n_cs=0, n_we=1 (write recovery).
//  Latency: ALU/LDI/JUMP/NOP 3 cycles, LDM/STM 4 cycles. Flags change only on ALU instructions.
//  Outputs are registered with state: reg_we high exactly one cycle, falls at next posedge.
//  Reset (res=0 at posedge): state=FETCH1, pc=RST_PC, ir1=ir2=0, flags=0, reg_we=0,
//   alu_func=0, addrs=0, reg_wsel=0, ram_n_cs=ram_n_oe=ram_n_we=1, halted=0.
//   Reset mid-instruction aborts it; reg_we/RAM strobes deasserted the same edge.
//  PC wraps modulo 2^PC_W; an instruction straddling the wrap fetches op2 from address 0.
//  Jump to current pc allowed (tight loop). Flags used by a jump are those before EXEC.
// CONFIGURATION
//  SEQ_HALT_EN defined: op1=8'h0F is HLT: EXEC -> HALT state, halted=1, all strobes idle,
//   pc frozen; leaves only on reset. Undefined: 8'h0F is NOP, halted tied 0.
// TESTING
//  Reset: res=0 two cycles -> pc=0, strobes idle, reg_we=0, state FETCH1.
//  LDI r5,8'h1F -> reg_we pulse in cycle 3, wr_addr=5, wsel=1, imm=8'h1F.
//  ALU SUB r1,r2->r3 with alu_zero=1 -> alu_func=001, flag_z=1 after cycle 3; JZ 8'h10 -> pc=8'h10.
//  STM r4->RAM[8'h40] then LDM r6<-RAM[8'h40] -> n_we low only in STM EXEC; n_oe low 2 cycles LDM.
//  PC at 8'hFF with PC_W=8 -> op2 fetched from 0, next fetch at 1.
//  SEQ_HALT_EN: 8'h0F -> halted=1, pc constant 20 cycles; reset clears. Without macro acts as NOP.

Source files
------------

// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if: ROM, ALU, register-file and RAM control bundle between the sequencer and the datapath.
interface cpu_sequencer_if #(parameter int PC_W = 8);
  logic [PC_W-1:0] rom_addr;
  logic [7:0] rom_data;
  logic alu_zero;
  logic alu_carry;
  logic [2:0] alu_func;
  logic [2:0] reg_rd_addr1;
  logic [2:0] reg_rd_addr2;
  logic [2:0] reg_wr_addr;
  logic reg_we;
  logic [1:0] reg_wsel;
  logic [7:0] imm;
  logic ram_n_cs;
  logic ram_n_oe;
  logic ram_n_we;
  logic flag_z;
  logic flag_c;
  logic halted;
  modport master (
    input rom_data, alu_zero, alu_carry,
    output rom_addr, alu_func, reg_rd_addr1, reg_rd_addr2, reg_wr_addr, reg_we, reg_wsel, imm,
    ram_n_cs, ram_n_oe, ram_n_we, flag_z, flag_c, halted
  );
  modport slave (
    output rom_data, alu_zero, alu_carry,
    input rom_addr, alu_func, reg_rd_addr1, reg_rd_addr2, reg_wr_addr, reg_we, reg_wsel, imm,
    ram_n_cs, ram_n_oe, ram_n_we, flag_z, flag_c, halted
  );
endinterface

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: fetch/decode/execute sequencer for the 8-bit CPU; define SEQ_HALT_EN to make 8'h0F a HLT.
// Control outputs are registered with the state, decoded from next state and next instruction bytes.
module cpu_sequencer #(
  parameter int PC_W = 8,
  parameter logic [PC_W-1:0] RST_PC = '0
) (
  input logic clk,
  input logic res,
  cpu_sequencer_if.master bus
);
  typedef enum logic [2:0] {FETCH1, FETCH2, EXEC, MEM, HALT} state_e;
  state_e state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0] ir1_q, ir1_d, ir2_q, ir2_d;
  logic flag_z_q, flag_z_d, flag_c_q, flag_c_d;
  logic [2:0] alu_func_q, alu_func_d, rd1_q, rd1_d, rd2_q, rd2_d, wr_q, wr_d;
  logic [1:0] wsel_q, wsel_d;
  logic we_q, we_d, n_cs_q, n_cs_d, n_oe_q, n_oe_d, n_we_q, n_we_d, halted_q, halted_d;
  logic is_alu, is_jmp, is_mem, is_hlt, taken, halt_en;
  logic x_alu, x_ldi, x_ldm, x_stm;
  logic [PC_W-1:0] tgt;
`ifdef SEQ_HALT_EN
  assign is_hlt = ir1_q == 8'h0F;
  assign halt_en = 1'b1;
`else
  assign is_hlt = 1'b0;
  assign halt_en = 1'b0;
`endif
  assign is_alu = ir1_q[7];
  assign is_jmp = ir1_q[7:6] == 2'b01;
  assign is_mem = ir1_q[7:5] == 3'b001;
  assign tgt = PC_W'(ir2_q);
  assign taken = ir1_q[5:4] == 2'b00 ? 1'b1 :
                 ir1_q[5:4] == 2'b01 ? flag_z_q :
                 ir1_q[5:4] == 2'b10 ? flag_c_q : !flag_z_q;
  always_ff @(posedge clk) begin
    if (!res) begin
      state_q <= FETCH1;
      pc_q <= RST_PC;
      ir1_q <= '0;
      ir2_q <= '0;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
      alu_func_q <= '0;
      rd1_q <= '0;
      rd2_q <= '0;
      wr_q <= '0;
      wsel_q <= '0;
      we_q <= 1'b0;
      n_cs_q <= 1'b1;
      n_oe_q <= 1'b1;
      n_we_q <= 1'b1;
      halted_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      ir1_q <= ir1_d;
      ir2_q <= ir2_d;
      flag_z_q <= flag_z_d;
      flag_c_q <= flag_c_d;
      alu_func_q <= alu_func_d;
      rd1_q <= rd1_d;
      rd2_q <= rd2_d;
      wr_q <= wr_d;
      wsel_q <= wsel_d;
      we_q <= we_d;
      n_cs_q <= n_cs_d;
      n_oe_q <= n_oe_d;
      n_we_q <= n_we_d;
      halted_q <= halted_d;
    end
  end
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    ir1_d = ir1_q;
    ir2_d = ir2_q;
    flag_z_d = flag_z_q;
    flag_c_d = flag_c_q;
    case (state_q)
      FETCH1: begin
        state_d = FETCH2;
        ir1_d = bus.rom_data;
        pc_d = pc_q + PC_W'(1);
      end
      FETCH2: begin
        state_d = EXEC;
        ir2_d = bus.rom_data;
        pc_d = pc_q + PC_W'(1);
      end
      EXEC: begin
        state_d = is_mem ? MEM : is_hlt ? HALT : FETCH1;
        pc_d = (is_jmp && taken) ? tgt : pc_q;
        flag_z_d = is_alu ? bus.alu_zero : flag_z_q;
        flag_c_d = is_alu ? bus.alu_carry : flag_c_q;
      end
      MEM: state_d = FETCH1;
      HALT: state_d = HALT;
      default: state_d = FETCH1;
    endcase
  end
  // LDM reads during EXEC and MEM, writing the register in MEM; STM strobes n_we in EXEC only
  always_comb begin
    x_alu = state_d == EXEC && ir1_d[7];
    x_ldi = state_d == EXEC && ir1_d[7:4] == 4'h1;
    x_ldm = (state_d == EXEC || state_d == MEM) && ir1_d[7:4] == 4'h2;
    x_stm = (state_d == EXEC || state_d == MEM) && ir1_d[7:4] == 4'h3;
    alu_func_d = x_alu ? ir1_d[6:4] : 3'd0;
    rd1_d = x_alu ? ir1_d[2:0] : 3'd0;
    rd2_d = x_alu ? ir2_d[6:4] : x_stm ? ir1_d[2:0] : 3'd0;
    wr_d = x_alu ? ir2_d[2:0] : (x_ldi || x_ldm) ? ir1_d[2:0] : 3'd0;
    we_d = x_alu || x_ldi || (x_ldm && state_d == MEM);
    wsel_d = x_ldi ? 2'd1 : x_ldm ? 2'd2 : 2'd0;
    n_cs_d = !(x_ldm || x_stm);
    n_oe_d = !x_ldm;
    n_we_d = !(x_stm && state_d == EXEC);
    halted_d = halt_en && state_d == HALT;
  end
  assign bus.rom_addr = pc_q;
  assign bus.alu_func = alu_func_q;
  assign bus.reg_rd_addr1 = rd1_q;
  assign bus.reg_rd_addr2 = rd2_q;
  assign bus.reg_wr_addr = wr_q;
  assign bus.reg_we = we_q;
  assign bus.reg_wsel = wsel_q;
  assign bus.imm = ir2_q;
  assign bus.ram_n_cs = n_cs_q;
  assign bus.ram_n_oe = n_oe_q;
  assign bus.ram_n_we = n_we_q;
  assign bus.flag_z = flag_z_q;
  assign bus.flag_c = flag_c_q;
  assign bus.halted = halted_q;
endmodule
